// File: rtl/route_concat_merge.sv
// -----------------------------------------------------------------------------
// route_concat_merge
// Merges two pixel-major feature streams along the channel axis (inverse of
// route split). For every pixel, all group-A beats are forwarded first, then
// all group-B beats, through a single registered output stage.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   Start, Clear        control: Start rising edge in IDLE launches a frame,
//                       Clear returns DONE to IDLE
//   Beats_A, Beats_B    beats per pixel for group A / group B
//   Pixels              pixels per frame
//   S_A_*               group A input stream (valid/ready)
//   S_B_*               group B input stream (valid/ready)
//   M_*                 merged output stream (valid/ready)
//   State               0000 idle, 0001 running, 1111 done
//
// Optional build macro ROUTE_CONCAT_LAST_EN adds output M_Last, marking the
// final beat of the frame.
// -----------------------------------------------------------------------------
module route_concat_merge #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned BEAT_WIDTH = 8,
    parameter int unsigned PIX_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic                  Clear,
    input  logic [BEAT_WIDTH-1:0] Beats_A,
    input  logic [BEAT_WIDTH-1:0] Beats_B,
    input  logic [PIX_WIDTH-1:0]  Pixels,
    input  logic [DATA_WIDTH-1:0] S_A_Data,
    input  logic                  S_A_Valid,
    output logic                  S_A_Ready,
    input  logic [DATA_WIDTH-1:0] S_B_Data,
    input  logic                  S_B_Valid,
    output logic                  S_B_Ready,
    output logic [DATA_WIDTH-1:0] M_Data,
    output logic                  M_Valid,
    input  logic                  M_Ready,
`ifdef ROUTE_CONCAT_LAST_EN
    output logic                  M_Last,
`endif
    output logic [3:0]            State
);

    localparam int unsigned SUM_WIDTH = BEAT_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PH_A  = 3'd2,
        ST_PH_B  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    state_e                state_q,      state_d;
    logic                  start_prev_q;
    logic [BEAT_WIDTH-1:0] beats_a_q,    beats_a_d;
    logic [BEAT_WIDTH-1:0] beats_b_q,    beats_b_d;
    logic [PIX_WIDTH-1:0]  pixels_q,     pixels_d;
    logic [BEAT_WIDTH-1:0] beat_cnt_q,   beat_cnt_d;
    logic [PIX_WIDTH-1:0]  pix_cnt_q,    pix_cnt_d;
    logic [DATA_WIDTH-1:0] m_data_q,     m_data_d;
    logic                  m_valid_q,    m_valid_d;
`ifdef ROUTE_CONCAT_LAST_EN
    logic                  m_last_q,     m_last_d;
`endif

    logic can_load_c;
    logic a_fire_c;
    logic b_fire_c;
    logic a_last_beat_c;
    logic b_last_beat_c;
    logic pix_last_c;
    logic cfg_empty_c;

    // Handshake: the output register can take a beat when empty or draining.
    always_comb begin
        can_load_c = !m_valid_q || M_Ready;
        S_A_Ready  = (state_q == ST_PH_A) && can_load_c;
        S_B_Ready  = (state_q == ST_PH_B) && can_load_c;
        a_fire_c   = S_A_Valid && S_A_Ready;
        b_fire_c   = S_B_Valid && S_B_Ready;
    end

    // End-of-phase / end-of-frame compares; a zero count never matches.
    always_comb begin
        a_last_beat_c = (beats_a_q != '0) &&
                        (beat_cnt_q == (beats_a_q - BEAT_WIDTH'(1)));
        b_last_beat_c = (beats_b_q != '0) &&
                        (beat_cnt_q == (beats_b_q - BEAT_WIDTH'(1)));
        pix_last_c    = (pixels_q != '0) &&
                        (pix_cnt_q == (pixels_q - PIX_WIDTH'(1)));
        cfg_empty_c   = (pixels_q == '0) ||
                        ((SUM_WIDTH'(beats_a_q) + SUM_WIDTH'(beats_b_q)) == '0);
    end

    // Next-state, counters and configuration latch.
    always_comb begin
        state_d    = state_q;
        beats_a_d  = beats_a_q;
        beats_b_d  = beats_b_q;
        pixels_d   = pixels_q;
        beat_cnt_d = beat_cnt_q;
        pix_cnt_d  = pix_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (Start && !start_prev_q) begin
                    beats_a_d  = Beats_A;
                    beats_b_d  = Beats_B;
                    pixels_d   = Pixels;
                    beat_cnt_d = '0;
                    pix_cnt_d  = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cfg_empty_c) begin
                    state_d = ST_DONE;
                end else if (beats_a_q == '0) begin
                    state_d = ST_PH_B;
                end else begin
                    state_d = ST_PH_A;
                end
            end
            ST_PH_A: begin
                if (a_fire_c) begin
                    if (a_last_beat_c) begin
                        beat_cnt_d = '0;
                        if (beats_b_q == '0) begin
                            // No B group: the A phase closes the pixel.
                            pix_cnt_d = pix_cnt_q + PIX_WIDTH'(1);
                            state_d   = pix_last_c ? ST_DRAIN : ST_PH_A;
                        end else begin
                            state_d = ST_PH_B;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_WIDTH'(1);
                    end
                end
            end
            ST_PH_B: begin
                if (b_fire_c) begin
                    if (b_last_beat_c) begin
                        beat_cnt_d = '0;
                        pix_cnt_d  = pix_cnt_q + PIX_WIDTH'(1);
                        if (pix_last_c) begin
                            state_d = ST_DRAIN;
                        end else if (beats_a_q == '0) begin
                            state_d = ST_PH_B;
                        end else begin
                            state_d = ST_PH_A;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!m_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (Clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register: a new load has priority over the downstream drain.
    always_comb begin
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
`ifdef ROUTE_CONCAT_LAST_EN
        m_last_d  = m_last_q;
`endif
        if (a_fire_c) begin
            m_data_d  = S_A_Data;
            m_valid_d = 1'b1;
`ifdef ROUTE_CONCAT_LAST_EN
            m_last_d  = a_last_beat_c && (beats_b_q == '0) && pix_last_c;
`endif
        end else if (b_fire_c) begin
            m_data_d  = S_B_Data;
            m_valid_d = 1'b1;
`ifdef ROUTE_CONCAT_LAST_EN
            m_last_d  = b_last_beat_c && pix_last_c;
`endif
        end else if (m_valid_q && M_Ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            beats_a_q    <= '0;
            beats_b_q    <= '0;
            pixels_q     <= '0;
            beat_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
`ifdef ROUTE_CONCAT_LAST_EN
            m_last_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            start_prev_q <= Start;
            beats_a_q    <= beats_a_d;
            beats_b_q    <= beats_b_d;
            pixels_q     <= pixels_d;
            beat_cnt_q   <= beat_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
`ifdef ROUTE_CONCAT_LAST_EN
            m_last_q     <= m_last_d;
`endif
        end
    end

    // Status decode shared with the other reshape ops.
    always_comb begin
        case (state_q)
            ST_IDLE: State = 4'b0000;
            ST_DONE: State = 4'b1111;
            default: State = 4'b0001;
        endcase
    end

    assign M_Data  = m_data_q;
    assign M_Valid = m_valid_q;
`ifdef ROUTE_CONCAT_LAST_EN
    assign M_Last  = m_last_q;
`endif

endmodule

// File: tb/tb_route_concat_merge.sv
// -----------------------------------------------------------------------------
// tb_route_concat_merge
// Randomized self-checking bench for route_concat_merge. The expected output
// of a frame is built from the source beat lists in pixel-major order (all A
// beats of a pixel, then all B beats) and compared against every accepted
// output beat. Build with ROUTE_CONCAT_LAST_EN to also check M_Last.
// -----------------------------------------------------------------------------
module tb_route_concat_merge;

    localparam int unsigned DW = 128;
    localparam int unsigned BW = 8;
    localparam int unsigned PW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          Start, Clear;
    logic [BW-1:0] Beats_A, Beats_B;
    logic [PW-1:0] Pixels;
    logic [DW-1:0] S_A_Data, S_B_Data, M_Data;
    logic          S_A_Valid, S_A_Ready, S_B_Valid, S_B_Ready;
    logic          M_Valid, M_Ready;
    logic [3:0]    State;
`ifdef ROUTE_CONCAT_LAST_EN
    logic          M_Last;
`endif

    route_concat_merge #(.DATA_WIDTH(DW), .BEAT_WIDTH(BW), .PIX_WIDTH(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .Clear     (Clear),
        .Beats_A   (Beats_A),
        .Beats_B   (Beats_B),
        .Pixels    (Pixels),
        .S_A_Data  (S_A_Data),
        .S_A_Valid (S_A_Valid),
        .S_A_Ready (S_A_Ready),
        .S_B_Data  (S_B_Data),
        .S_B_Valid (S_B_Valid),
        .S_B_Ready (S_B_Ready),
        .M_Data    (M_Data),
        .M_Valid   (M_Valid),
        .M_Ready   (M_Ready),
`ifdef ROUTE_CONCAT_LAST_EN
        .M_Last    (M_Last),
`endif
        .State     (State)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [DW-1:0] a_mem[$];
    logic [DW-1:0] b_mem[$];
    logic [DW-1:0] exp_q[$];

    // mode: 0 streaming, 1 M_Ready toggles, 2 random valid/ready,
    //       3 A source gap of 5 cycles with B held valid.
    // abort_at > 0: stop after that many output beats (caller applies reset).
    task automatic run_frame(input int ba, input int bb, input int px,
                             input int mode, input int abort_at);
        int a_idx = 0;
        int b_idx = 0;
        int out_cnt = 0;
        int cyc = 0;
        int gap = 0;
        int w = 0;
        int n;
        bit prev_stall = 0;
        logic [DW-1:0] prev_data = '0;

        a_mem.delete(); b_mem.delete(); exp_q.delete();
        for (int i = 0; i < ba * px; i++) a_mem.push_back(rnd128());
        for (int i = 0; i < bb * px; i++) b_mem.push_back(rnd128());
        // Reference: pixel-major, A group then B group per pixel.
        for (int p = 0; p < px; p++) begin
            for (int k = 0; k < ba; k++) exp_q.push_back(a_mem[p * ba + k]);
            for (int k = 0; k < bb; k++) exp_q.push_back(b_mem[p * bb + k]);
        end
        n = exp_q.size();

        Beats_A = BW'(ba);
        Beats_B = BW'(bb);
        Pixels  = PW'(px);
        Start   = 1'b1;
        @(negedge clk);
        Start   = 1'b0;
        check("state_run", 128'(State), 128'(4'b0001));

        while (out_cnt < n && cyc < 4000) begin
            case (mode)
                1:       M_Ready = cyc[0];
                2:       M_Ready = 1'($urandom_range(0, 1));
                default: M_Ready = 1'b1;
            endcase
            if (mode == 3 && a_idx == 2 && gap < 5) begin
                S_A_Valid = 1'b0;
                gap++;
            end else if (mode == 2) begin
                S_A_Valid = (a_idx < a_mem.size()) && ($urandom_range(0, 3) != 0);
            end else begin
                S_A_Valid = (a_idx < a_mem.size());
            end
            if (mode == 2) S_B_Valid = (b_idx < b_mem.size()) && ($urandom_range(0, 3) != 0);
            else if (mode == 3) S_B_Valid = 1'b1;
            else S_B_Valid = (b_idx < b_mem.size());
            S_A_Data = (a_idx < a_mem.size()) ? a_mem[a_idx] : rnd128();
            S_B_Data = (b_idx < b_mem.size()) ? b_mem[b_idx] : rnd128();
            #1;
            check("rdy_excl", 128'(S_A_Ready && S_B_Ready), 128'(0));
            if (ba == 0) check("a_rdy_off", 128'(S_A_Ready), 128'(0));
            if (prev_stall) begin
                check("hold_valid", 128'(M_Valid), 128'(1));
                check("hold_data", M_Data, prev_data);
            end
            prev_stall = M_Valid && !M_Ready;
            prev_data  = M_Data;
            if (M_Valid && M_Ready) begin
                check("out_data", M_Data, exp_q[out_cnt]);
`ifdef ROUTE_CONCAT_LAST_EN
                check("out_last", 128'(M_Last), 128'(out_cnt == n - 1));
`endif
                out_cnt++;
            end
            if (S_A_Valid && S_A_Ready) a_idx++;
            if (S_B_Valid && S_B_Ready) b_idx++;
            @(negedge clk);
            cyc++;
            if (abort_at > 0 && out_cnt >= abort_at) break;
        end
        S_A_Valid = 1'b0;
        S_B_Valid = 1'b0;
        M_Ready   = 1'b1;
        if (abort_at > 0) begin
            check("abort_reached", 128'(out_cnt >= abort_at), 128'(1));
            return;
        end

        check("beats_out", 128'(out_cnt), 128'(n));
        check("a_taken", 128'(a_idx), 128'(a_mem.size()));
        check("b_taken", 128'(b_idx), 128'(b_mem.size()));
        while (State != 4'b1111 && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("done_state", 128'(State), 128'(4'b1111));
        check("done_lat", 128'(w), 128'(1));
        check("done_valid", 128'(M_Valid), 128'(0));
        Clear = 1'b1;
        @(negedge clk);
        Clear = 1'b0;
        check("clear_idle", 128'(State), 128'(4'b0000));
    endtask

    initial begin
        rst = 1'b0; Start = 1'b0; Clear = 1'b0;
        Beats_A = '0; Beats_B = '0; Pixels = '0;
        S_A_Data = '0; S_B_Data = '0; S_A_Valid = 1'b0; S_B_Valid = 1'b0;
        M_Ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 128'(M_Valid), 128'(0));
        check("rst_data", M_Data, 128'(0));
        check("rst_state", 128'(State), 128'(0));
        check("rst_a_rdy", 128'(S_A_Ready), 128'(0));
        check("rst_b_rdy", 128'(S_B_Ready), 128'(0));
`ifdef ROUTE_CONCAT_LAST_EN
        check("rst_last", 128'(M_Last), 128'(0));
`endif
        rst = 1'b1;
        @(negedge clk);

        run_frame(4, 4, 2, 0, 0);   // basic merge
        run_frame(4, 4, 2, 1, 0);   // backpressure
        run_frame(0, 3, 3, 2, 0);   // B only
        run_frame(3, 0, 2, 2, 0);   // A only
        run_frame(4, 4, 2, 3, 0);   // A source gap
        run_frame(2, 2, 4, 2, 0);   // 16 beats, M_Last on last
        run_frame(2, 2, 0, 0, 0);   // zero pixels
        run_frame(0, 0, 3, 0, 0);   // zero beats

        // Start held high: ignored in DONE, and no relaunch after Clear.
        Beats_A = 8'd1; Beats_B = 8'd1; Pixels = '0;
        Start = 1'b1;
        repeat (3) @(negedge clk);
        check("done_start_hi", 128'(State), 128'(4'b1111));
        Clear = 1'b1;
        @(negedge clk);
        Clear = 1'b0;
        repeat (2) @(negedge clk);
        check("start_level", 128'(State), 128'(4'b0000));
        Start = 1'b0;
        @(negedge clk);

        // Reset in the B phase of pixel 1.
        run_frame(2, 2, 3, 0, 6);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 128'(M_Valid), 128'(0));
        check("mid_rst_state", 128'(State), 128'(0));
        check("mid_rst_b_rdy", 128'(S_B_Ready), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        run_frame(2, 2, 3, 0, 0);

        for (int r = 0; r < 6; r++) begin
            run_frame(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/route_concat_merge.md
Name: route_concat_merge

Overview:
- Reshape-path block that merges two 128-bit feature streams along the channel axis; it is the inverse of route split.
- Group A (for example the earlier route layer) and group B (the current layer) arrive as separate pixel-major streams.
- Per pixel, all A beats are emitted, then all B beats, on one output stream toward the DMA write side.
- Started and cleared by the reshape control word; reports status in the same 4-bit state encoding as the other reshape ops.

Parameters:
DATA_WIDTH, 128, stream beat width (16 channels x 8 bit per beat)
BEAT_WIDTH, 8, width of per-pixel beat-count config fields
PIX_WIDTH, 20, width of pixel-count config field

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low (0 = reset)
Start  input  1  level; rising edge sampled in IDLE launches a frame
Clear  input  1  pulse; returns DONE to IDLE
Beats_A  input  BEAT_WIDTH  A beats per pixel (channels_A/16)
Beats_B  input  BEAT_WIDTH  B beats per pixel
Pixels  input  PIX_WIDTH  pixels per frame (rows*cols)
S_A_Data  input  DATA_WIDTH  group A data
S_A_Valid  input  1  group A valid
S_A_Ready  output  1  group A ready
S_B_Data  input  DATA_WIDTH  group B data
S_B_Valid  input  1  group B valid
S_B_Ready  output  1  group B ready
M_Data  output  DATA_WIDTH  merged data
M_Valid  output  1  merged valid
M_Ready  input  1  downstream ready
State  output  4  0000 idle, 0001 running, 1111 done

Behaviour:
- Reset (rst=0 at posedge): FSM=IDLE, all counters 0, M_Valid=0, M_Data=0, S_A_Ready=0, S_B_Ready=0, State=0000. Reset mid-frame aborts immediately; buffered data is discarded.
- IDLE: a Start rising edge (Start=1, previous Start=0) latches Beats_A, Beats_B, Pixels and moves to LOAD. A level-high Start with no rising edge is ignored.
- LOAD (1 cycle):
  - Pixels=0, or Beats_A+Beats_B=0 -> DONE.
  - Else Beats_A=0 -> PH_B.
  - Else -> PH_A.
- Output register: one stage. Define can_load = !M_Valid || M_Ready.
  - S_A_Ready = (FSM==PH_A) && can_load.
  - S_B_Ready = (FSM==PH_B) && can_load.
  - Both readies are combinational from registered state and M_Valid/M_Ready; never both high.
- Input transfer: Valid && Ready at posedge loads M_Data, sets M_Valid=1 and increments beat_cnt.
- Output side: when M_Valid && M_Ready and no new load in that cycle, M_Valid clears. Latency is 1 cycle input->output. Full throughput is one beat per cycle with M_Ready held high.
- PH_A: when the transfer has beat_cnt==Beats_A-1, beat_cnt goes to 0 and the FSM moves to PH_B, or to the next pixel in PH_A if Beats_B=0.
- PH_B: when the transfer has beat_cnt==Beats_B-1, beat_cnt goes to 0 and pix_cnt increments.
  - pix_cnt==Pixels-1 -> DRAIN.
  - Else -> PH_A, or PH_B if Beats_A=0.
- DRAIN: waits until M_Valid=0 (last beat accepted), then -> DONE.
- DONE: State=1111. Holds until Clear=1, then -> IDLE. Start is ignored in DONE.
- Clear in IDLE, LOAD, PH_A, PH_B or DRAIN has no effect.
- Data passes through unmodified; no reordering within a phase.
- Stalls:
  - The input of the inactive group is never acknowledged, even if valid.
  - M_Ready low holds M_Data/M_Valid stable, and the active ready drops the same cycle.
- Counters: beat_cnt is BEAT_WIDTH bits, pix_cnt is PIX_WIDTH bits. Compare against latched value minus 1 only when that value is nonzero.
- State=0001 in LOAD, PH_A, PH_B and DRAIN.

Optional Feature:
- Macro: ROUTE_CONCAT_LAST_EN.
- When defined:
  - Adds output port M_Last (1 bit), registered with M_Data.
  - M_Last is 1 on the final beat of the frame (last B beat of the last pixel, or last A beat if Beats_B=0), else 0.
  - M_Last resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic merge: Beats_A=4, Beats_B=4, Pixels=2, both sources always valid, M_Ready=1 -> 16 output beats ordered A0..A3,B0..B3,A4..A7,B4..B7. State goes 0001, then 1111 one cycle after the last beat is accepted; Clear -> 0000.
- Backpressure: same config, M_Ready toggled 1/0 each cycle -> no beat lost or duplicated, and M_Data is stable while M_Valid=1 && M_Ready=0. S_B_Ready is never high during the A phase.
- Degenerate groups:
  - Beats_A=0, Beats_B=3, Pixels=3 -> 9 B beats only; S_A_Ready is never asserted.
  - Pixels=0 -> State 1111 two cycles after Start with no output.
- Source gaps: S_A_Valid low for 5 cycles mid-pixel while S_B_Valid is held high -> output waits, with no B beat emitted before A completes the pixel.
- Reset mid-frame: rst=0 during PH_B of pixel 1 -> next cycle M_Valid=0, State=0000. A fresh Start runs a full frame correctly.
- ROUTE_CONCAT_LAST_EN build, Beats_A=2, Beats_B=2, Pixels=4 -> M_Last=1 only on the 16th output beat.
